seg_scan_decoder: RTL and testbench

Receive-side counterpart of the calculator's multiplexed seven-segment display driver. Samples the scanned `an`/`seg` bus, filters each anode dwell for stability, decodes each segment pattern back to a hex nibble, and publishes a complete 4-digit frame with a one-cycle valid pulse. Used both as an on-chip readback of the displayed result and as a self-checking monitor in the calculator bench.

---
 rtl/seg_scan_pkg.sv | 36 +++
 rtl/seg_pattern_decode.sv | 24 ++
 rtl/seg_scan_decoder.sv | 175 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan decoder.
// Holds the FSM state enum, the hex segment table and anode helper functions.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  localparam logic [3:0] AN_NONE = 4'hF;

  // Active-high gfedcba patterns for hex digits 0..F.
  localparam logic [6:0] SEG_PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic an_onehot_low(input logic [3:0] an);
    logic [3:0] sel;
    sel = ~an;
    return (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] an_index(input logic [3:0] an);
    logic [1:0] idx;
    case (an)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decode of an active-high gfedcba pattern to a hex nibble.
// All-off decodes as a legal blank digit; unknown patterns are illegal.
module seg_pattern_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    nibble = 4'd0;
    blank  = (pat == 7'h00);
    legal  = (pat == 7'h00);
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_PAT[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers 4-digit frames from a scanned, active-low an/seg display bus.
// Define SEG_SCAN_SYNC_EN to add a two-flop input synchronizer (2 cycles latency).
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  input  logic        clr,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic        err,
  output logic        stale,
  output state_t      fsm_state
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 2);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  logic [11:0] smp;

`ifdef SEG_SCAN_SYNC_EN
  logic [11:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 12'hFFF;
      sync2_q <= 12'hFFF;
    end else begin
      sync1_q <= {an, seg};
      sync2_q <= sync1_q;
    end
  end
  assign smp = sync2_q;
`else
  assign smp = {an, seg};
`endif

  // Dwell filter: one capture when a stable value has been seen STABLE_CYCLES times.
  logic [11:0]   prev_d, prev_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          capture;

  always_comb begin
    prev_d = smp;
    cnt_d  = cnt_q;
    if (smp != prev_q)        cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  assign capture = (smp == prev_q) && (cnt_q == CNT_PRE);

  logic [3:0] cap_an;
  logic [7:0] cap_seg;
  logic [6:0] cap_pat;
  logic [3:0] dec_nib;
  logic       dec_legal, dec_blank;
  logic       cap_digit, cap_bad_an, err_set;
  logic [1:0] idx;

  assign cap_an     = prev_q[11:8];
  assign cap_seg    = prev_q[7:0];
  assign cap_pat    = ~cap_seg[6:0];
  assign cap_digit  = capture && an_onehot_low(cap_an);
  assign cap_bad_an = capture && (cap_an != AN_NONE) && !an_onehot_low(cap_an);
  assign err_set    = cap_bad_an || (cap_digit && !dec_legal);
  assign idx        = an_index(cap_an);

  seg_pattern_decode u_decode (
    .pat    (cap_pat),
    .nibble (dec_nib),
    .legal  (dec_legal),
    .blank  (dec_blank)
  );

  state_t state_d, state_q;
  logic [3:0]  seen_d, seen_q, seen_upd;
  logic [15:0] sh_nib_d, sh_nib_q, digits_d, digits_q;
  logic [3:0]  sh_dp_d, sh_dp_q, sh_blank_d, sh_blank_q;
  logic [3:0]  dp_d, dp_q, blank_d, blank_q;
  logic        err_d, err_q;
  logic [TW-1:0] tmo_d, tmo_q;

  assign seen_upd = seen_q | (4'b0001 << idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cap_digit && idx == 2'd0) state_d = COLLECT;
      COLLECT: if (cap_digit && seen_upd == 4'hF) state_d = PUBLISH;
      PUBLISH: state_d = COLLECT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    frame_valid = (state_q == PUBLISH);
    fsm_state   = state_q;
  end

  // Shadow digits fill during COLLECT; outputs load on the edge entering PUBLISH.
  always_comb begin
    seen_d     = seen_q;
    sh_nib_d   = sh_nib_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    digits_d   = digits_q;
    dp_d       = dp_q;
    blank_d    = blank_q;
    if (cap_digit && (state_q != IDLE || idx == 2'd0)) begin
      sh_nib_d[{idx, 2'b00} +: 4] = dec_nib;
      sh_dp_d[idx]                = ~cap_seg[7];
      sh_blank_d[idx]             = dec_blank;
      seen_d                      = seen_upd;
    end
    if (state_d == PUBLISH) begin
      digits_d = sh_nib_d;
      dp_d     = sh_dp_d;
      blank_d  = sh_blank_d;
      seen_d   = 4'd0;
    end
    err_d = err_set ? 1'b1 : (clr ? 1'b0 : err_q);
    if (frame_valid)          tmo_d = '0;
    else if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
    else                      tmo_d = tmo_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q     <= 12'hFFF;
      cnt_q      <= '0;
      seen_q     <= 4'd0;
      sh_nib_q   <= 16'd0;
      sh_dp_q    <= 4'd0;
      sh_blank_q <= 4'hF;
      digits_q   <= 16'd0;
      dp_q       <= 4'd0;
      blank_q    <= 4'hF;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      sh_nib_q   <= sh_nib_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      digits_q   <= digits_d;
      dp_q       <= dp_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign digits = digits_q;
  assign dp     = dp_q;
  assign blank  = blank_q;
  assign err    = err_q;
  assign stale  = (tmo_q == TMO_MAX) && !frame_valid;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans digit frames over an/seg and
// compares published frames, error and stale flags against hand-derived values.
module tb_seg_scan_decoder;
  import seg_scan_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  an_i = 4'hF;
  logic [7:0]  seg_i = 8'hFF;
  logic        clr = 1'b0;
  logic [15:0] digits;
  logic [3:0]  dp, blank;
  logic        frame_valid, err, stale;
  state_t      fsm_state;

  int n_pass = 0;
  int n_total = 0;
  int fv_cnt = 0;

  seg_scan_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an_i),
    .seg         (seg_i),
    .clr         (clr),
    .digits      (digits),
    .dp          (dp),
    .blank       (blank),
    .frame_valid (frame_valid),
    .err         (err),
    .stale       (stale),
    .fsm_state   (fsm_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid === 1'b1) fv_cnt++;

  // ---- driver tasks ----
  task automatic show(input int idx, input logic [6:0] pat, input logic dpv, input int n);
    an_i  = ~(4'b0001 << idx);
    seg_i = {~dpv, ~pat};
    repeat (n) @(negedge clk);
  endtask

  task automatic gap(input int n);
    an_i  = 4'hF;
    seg_i = 8'hFF;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] p0, p1, p2, p3, input logic [3:0] dps);
    show(0, p0, dps[0], 8); gap(3);
    show(1, p1, dps[1], 8); gap(3);
    show(2, p2, dps[2], 8); gap(3);
    show(3, p3, dps[3], 8); gap(3);
  endtask

  task automatic pulse_clr();
    clr = 1'b1; @(negedge clk); clr = 1'b0; @(negedge clk);
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (digits !== 16'h0000 || dp !== 4'h0 || blank !== 4'hF || frame_valid !== 1'b0 ||
        err !== 1'b0 || stale !== 1'b0 || fsm_state !== IDLE) begin
      $display("FAIL reset_values: got digits=%h dp=%b blank=%b fv=%b err=%b stale=%b st=%0d want 0000/0000/1111/0/0/0/0",
               digits, dp, blank, frame_valid, err, stale, fsm_state);
    end else n_pass++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_0002();
    int fv0;
    fv0 = fv_cnt;
    scan(7'h5B, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
    n_total++;
    if (fv_cnt - fv0 !== 1) $display("FAIL frame_0002_pulses: got %0d want 1", fv_cnt - fv0);
    else n_pass++;
    n_total++;
    if (digits !== 16'h0002 || err !== 1'b0 || blank !== 4'h0 || dp !== 4'h0)
      $display("FAIL frame_0002: got digits=%h err=%b blank=%b dp=%b want 0002/0/0000/0000", digits, err, blank, dp);
    else n_pass++;
  endtask

  task automatic test_fedc();
    scan(7'h39, 7'h5E, 7'h79, 7'h71, 4'b0010);
    n_total++;
    if (digits !== 16'hFEDC || dp !== 4'b0010)
      $display("FAIL frame_fedc: got digits=%h dp=%b want FEDC/0010", digits, dp);
    else n_pass++;
  endtask

  task automatic test_blank_err();
    scan(7'h06, 7'h49, 7'h00, 7'h07, 4'b0000);
    n_total++;
    if (digits !== 16'h7001 || blank !== 4'b0100)
      $display("FAIL blank_digit: got digits=%h blank=%b want 7001/0100", digits, blank);
    else n_pass++;
    n_total++;
    if (err !== 1'b1) $display("FAIL illegal_pattern_err: got %b want 1", err);
    else n_pass++;
    pulse_clr();
    n_total++;
    if (err !== 1'b0) $display("FAIL clr_err: got %b want 0", err);
    else n_pass++;
  endtask

  task automatic test_multi_hot();
    int fv0;
    fv0 = fv_cnt;
    show(0, 7'h06, 1'b0, 8); gap(3);
    show(1, 7'h5B, 1'b0, 8); gap(3);
    an_i = 4'b1100; seg_i = {1'b1, ~7'h4F};
    repeat (8) @(negedge clk);
    gap(3);
    n_total++;
    if (err !== 1'b1 || fv_cnt != fv0)
      $display("FAIL multi_hot_err: got err=%b frames=%0d want 1/0", err, fv_cnt - fv0);
    else n_pass++;
    show(2, 7'h4F, 1'b0, 8); gap(3);
    show(3, 7'h66, 1'b0, 8); gap(3);
    n_total++;
    if (fv_cnt - fv0 !== 1 || digits !== 16'h4321)
      $display("FAIL multi_hot_seen_kept: got frames=%0d digits=%h want 1/4321", fv_cnt - fv0, digits);
    else n_pass++;
    pulse_clr();
  endtask

  task automatic test_glitch();
    int fv0;
    fv0 = fv_cnt;
    show(0, 7'h6D, 1'b0, 8); gap(3);
    show(1, 7'h7D, 1'b0, 8); gap(3);
    show(2, 7'h07, 1'b0, 8); gap(3);
    show(3, 7'h7F, 1'b0, 2); gap(3);
    an_i = 4'b0000; seg_i = 8'h00;
    repeat (2) @(negedge clk);
    gap(3);
    n_total++;
    if (fv_cnt != fv0 || err !== 1'b0)
      $display("FAIL glitch_ignored: got frames=%0d err=%b want 0/0", fv_cnt - fv0, err);
    else n_pass++;
    show(3, 7'h6F, 1'b0, 8); gap(3);
    n_total++;
    if (fv_cnt - fv0 !== 1 || digits !== 16'h9765)
      $display("FAIL after_glitch_frame: got frames=%0d digits=%h want 1/9765", fv_cnt - fv0, digits);
    else n_pass++;
  endtask

  task automatic test_stale();
    gap(1000);
    n_total++;
    if (stale !== 1'b0) $display("FAIL stale_early: got %b want 0", stale);
    else n_pass++;
    gap(100);
    n_total++;
    if (stale !== 1'b1) $display("FAIL stale_set: got %b want 1", stale);
    else n_pass++;
    scan(7'h3F, 7'h06, 7'h3F, 7'h06, 4'b0000);
    n_total++;
    if (stale !== 1'b0 || digits !== 16'h1010)
      $display("FAIL stale_clear: got stale=%b digits=%h want 0/1010", stale, digits);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    an_i = 4'b0000; seg_i = 8'h00;
    repeat (8) @(negedge clk);
    gap(3);
    show(0, 7'h66, 1'b1, 8); gap(3);
    show(1, 7'h66, 1'b0, 4);
    rst = 1'b0;
    #1;
    n_total++;
    if (digits !== 16'h0000 || dp !== 4'h0 || blank !== 4'hF || frame_valid !== 1'b0 ||
        err !== 1'b0 || stale !== 1'b0 || fsm_state !== IDLE)
      $display("FAIL reset_mid_frame: got digits=%h dp=%b blank=%b fv=%b err=%b stale=%b st=%0d want 0000/0000/1111/0/0/0/0",
               digits, dp, blank, frame_valid, err, stale, fsm_state);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    gap(2);
  endtask

  task automatic test_start_mid_scan();
    int fv0;
    fv0 = fv_cnt;
    show(2, 7'h6D, 1'b0, 8); gap(3);
    show(3, 7'h6D, 1'b0, 8); gap(3);
    show(1, 7'h6D, 1'b0, 8); gap(3);
    n_total++;
    if (fv_cnt != fv0 || fsm_state !== IDLE)
      $display("FAIL no_frame_before_d0: got frames=%0d st=%0d want 0/0", fv_cnt - fv0, fsm_state);
    else n_pass++;
    show(0, 7'h77, 1'b0, 8); gap(3);
    show(1, 7'h7C, 1'b0, 8); gap(3);
    n_total++;
    if (fv_cnt != fv0) $display("FAIL no_frame_partial: got %0d want 0", fv_cnt - fv0);
    else n_pass++;
    show(2, 7'h39, 1'b0, 8); gap(3);
    show(3, 7'h5E, 1'b1, 8); gap(3);
    n_total++;
    if (fv_cnt - fv0 !== 1 || digits !== 16'hDCBA || dp !== 4'b1000)
      $display("FAIL first_frame_after_reset: got frames=%0d digits=%h dp=%b want 1/DCBA/1000",
               fv_cnt - fv0, digits, dp);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_0002();
    test_fedc();
    test_blank_err();
    test_multi_hot();
    test_glitch();
    test_stale();
    test_reset_mid_frame();
    test_start_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
